// File: rtl/ram_pkg.sv
`default_nettype none
// Shared widths, FSM state type and a small bit-count helper for the RAM stream reader.
package ram_pkg;

  localparam int WORD_W = 32;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;

  function automatic logic [2:0] ones4(input logic [3:0] v);
    ones4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ram_read_fifo.sv
`default_nettype none
// Synchronous FIFO buffering returned RAM words; simultaneous push/pop is allowed when full or empty.
module ram_read_fifo
  import ram_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = WORD_W,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;

  // Pop on empty is only legal together with a push (word passes straight through).
  assign do_pop  = pop && (!empty || push);
  assign do_push = push && (!full || pop);
  assign head    = empty ? push_data : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ram_stream_reader.sv
`default_nettype none
// Burst reader: issues sequential RAM reads and streams the returned words out over valid/ready.
module ram_stream_reader
  import ram_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  output logic              busy,
  output logic              done,
  output logic              write_enable,
  output logic [ADDR_W-1:0] address,
  output logic [WORD_W-1:0] data_input,
  input  logic [WORD_W-1:0] data_output,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_last
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t                  state;
  state_t                  state_next;
  logic [ADDR_W-1:0]       base_q;
  logic [CNT_W-1:0]        count_q;
  logic [CNT_W-1:0]        issued;
  logic [CNT_W-1:0]        streamed;
  logic [ADDR_W-1:0]       addr_hold;
  logic [READ_LATENCY-1:0] inflight_sr;
  logic [2:0]              inflight;
  logic [ADDR_W-1:0]       issue_addr;
  logic                    room;
  logic                    issue;
  logic                    accept;
  logic                    pop;
  logic                    last_word;
  logic [WORD_W-1:0]       fifo_head;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [CW-1:0]           fifo_count;

  assign write_enable = 1'b0;
  assign data_input   = '0;

  assign inflight   = ones4(4'(inflight_sr));
  assign issue_addr = base_q + ADDR_W'(issued);
  // Reads still in flight already own a FIFO slot, so a returned word always has room.
  assign room       = (32'(inflight) + 32'(fifo_count)) < 32'(FIFO_DEPTH);
  assign issue      = (state == ISSUE) && (issued != count_q) && room && !fifo_full;
  assign accept     = (state == IDLE) && start;
  assign address    = issue ? issue_addr : addr_hold;

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_empty ? '0 : fifo_head;
  assign pop       = out_valid && out_ready;
  assign last_word = (streamed == count_q - 1'b1);
  assign out_last  = out_valid && last_word;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = (word_count == '0) ? FINISH : ISSUE;
      end
      ISSUE: begin
        if (issue && (issued == count_q - 1'b1)) state_next = DRAIN;
      end
      DRAIN: begin
        if (pop && last_word && (inflight == 3'd0)) state_next = FINISH;
      end
      FINISH: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q      <= '0;
      count_q     <= '0;
      issued      <= '0;
      streamed    <= '0;
      addr_hold   <= '0;
      inflight_sr <= '0;
    end else begin
      inflight_sr <= (inflight_sr << 1) | READ_LATENCY'(issue);
      if (accept) begin
        base_q   <= base_addr;
        count_q  <= word_count;
        issued   <= '0;
        streamed <= '0;
      end else begin
        if (issue) begin
          issued    <= issued + 1'b1;
          addr_hold <= issue_addr;
        end
        if (pop) streamed <= streamed + 1'b1;
      end
    end
  end

  ram_read_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_sr[READ_LATENCY-1]),
    .push_data (data_output),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_ram_stream_reader.sv
`default_nettype none
// Bench for ram_stream_reader: table of bursts, directed corner cases, and a latency-3 random-ready run.
module tb_ram_stream_reader;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_t;

  typedef struct {
    logic [31:0] base;
    logic [15:0] count;
    int          exp_latency;
    int          exp_done_off;
    logic [31:0] exp_first;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, out_ready;
  logic [31:0] base_addr;
  logic [15:0] word_count;
  logic        busy, done, write_enable, out_valid, out_last;
  logic [31:0] address, data_input, data_output, out_data;

  logic        start3, ready3;
  logic [31:0] base3;
  logic [15:0] count3;
  logic        busy3, done3, we3, valid3, last3;
  logic [31:0] address3, din3, dout3, data3;

  logic [31:0] ram [256];
  logic [31:0] pipe1;
  logic [31:0] pipe3 [3];

  exp_t q1[$];
  exp_t q3[$];
  int checks = 0, errors = 0;
  int words1 = 0, words3 = 0, done_cnt = 0, we_viol = 0, we_viol3 = 0;

  ram_stream_reader #(.READ_LATENCY(1), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_count(word_count),
    .busy(busy), .done(done), .write_enable(write_enable), .address(address),
    .data_input(data_input), .data_output(data_output), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  ram_stream_reader #(.READ_LATENCY(3), .FIFO_DEPTH(4)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .base_addr(base3), .word_count(count3),
    .busy(busy3), .done(done3), .write_enable(we3), .address(address3),
    .data_input(din3), .data_output(dout3), .out_valid(valid3),
    .out_ready(ready3), .out_data(data3), .out_last(last3)
  );

  // Synchronous RAM models with 1 and 3 cycles of read latency.
  always @(posedge clk) pipe1 <= ram[address[7:0]];
  assign data_output = pipe1;
  always @(posedge clk) begin
    pipe3[0] <= ram[address3[7:0]];
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign dout3 = pipe3[2];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic monitor1();
    exp_t e;
    forever begin
      @(negedge clk);
      if (write_enable !== 1'b0 || data_input !== 32'h0) we_viol++;
      if (done === 1'b1) done_cnt++;
      if (!rst && out_valid && out_ready) begin
        words1++;
        if (q1.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word got=%h exp=none", out_data);
        end else begin
          e = q1.pop_front();
          check("stream_data", out_data, e.data);
          check("stream_last", 32'(out_last), 32'(e.last));
        end
      end
    end
  endtask

  task automatic monitor3();
    exp_t e;
    forever begin
      @(negedge clk);
      if (we3 !== 1'b0 || din3 !== 32'h0) we_viol3++;
      if (!rst && valid3 && ready3) begin
        words3++;
        if (q3.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word3 got=%h exp=none", data3);
        end else begin
          e = q3.pop_front();
          check("stream3_data", data3, e.data);
          check("stream3_last", 32'(last3), 32'(e.last));
        end
      end
    end
  endtask

  task automatic start_burst(input logic [31:0] b, input logic [15:0] n, input bit expect_accept);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; word_count = n;
    if (expect_accept) begin
      for (int i = 0; i < int'(n); i++) begin
        logic [31:0] a;
        a = b + 32'(i);
        q1.push_back('{ram[a[7:0]], (i == int'(n) - 1)});
      end
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int cyc;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (done !== 1'b1 && cyc < limit);
    check("done_seen", 32'(done), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[4];
    int   cyc, w0, dc;
    logic [31:0] a0;

    for (int i = 0; i < 256; i++) ram[i] = 32'hA5000000 ^ (32'(i) * 32'h00010203);
    ram[1] = 32'h0000FA32;
    ram[2] = 32'h0000EA99;
    ram[3] = 32'h00001234;

    vecs[0] = '{32'd1,   16'd3,  2, 3,  32'h0000FA32};
    vecs[1] = '{32'd100, 16'd1,  2, 1,  ram[100]};
    vecs[2] = '{32'd200, 16'd5,  2, 5,  ram[200]};
    vecs[3] = '{32'd250, 16'd12, 2, 12, ram[250]};

    rst = 1'b1; start = 1'b0; base_addr = '0; word_count = '0; out_ready = 1'b1;
    start3 = 1'b0; base3 = '0; count3 = '0; ready3 = 1'b0;
    fork
      monitor1();
      monitor3();
    join_none
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_last", 32'(out_last), 0);
    check("rst_address", address, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy3", 32'(busy3), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Full-rate bursts: latency and one word per cycle until done.
    for (int v = 0; v < 4; v++) begin
      start_burst(vecs[v].base, vecs[v].count, 1'b1);
      cyc = 0;
      @(negedge clk);
      while (!out_valid && cyc < 50) begin
        cyc++;
        @(negedge clk);
      end
      check("first_latency", cyc, vecs[v].exp_latency);
      check("first_word", out_data, vecs[v].exp_first);
      cyc = 0;
      while (done !== 1'b1 && cyc < 200) begin
        @(negedge clk);
        cyc++;
      end
      check("done_offset", cyc, vecs[v].exp_done_off);
      @(negedge clk);
      check("idle_after_done", 32'(busy), 0);
      check("queue_empty", q1.size(), 0);
    end

    // Zero-length burst.
    @(negedge clk);
    a0 = address;
    start_burst(32'h77, 16'd0, 1'b1);
    @(negedge clk);
    check("zero_busy", 32'(busy), 1);
    check("zero_done", 32'(done), 1);
    check("zero_valid", 32'(out_valid), 0);
    check("zero_addr", address, a0);
    @(negedge clk);
    check("zero_busy_end", 32'(busy), 0);
    check("zero_done_end", 32'(done), 0);
    check("zero_addr_end", address, a0);

    // Backpressure: only FIFO_DEPTH reads may be outstanding.
    @(posedge clk); #1;
    out_ready = 1'b0;
    w0 = words1;
    start_burst(32'd40, 16'd8, 1'b1);
    repeat (10) @(negedge clk);
    check("bp_valid", 32'(out_valid), 1);
    check("bp_addr_held", address, 32'd43);
    check("bp_head", out_data, ram[40]);
    check("bp_no_pops", words1 - w0, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_done(100);
    check("bp_words", words1 - w0, 8);
    check("bp_queue_empty", q1.size(), 0);

    // Address wrap and a start request arriving mid-burst.
    start_burst(32'hFFFFFFFF, 16'd2, 1'b1);
    @(negedge clk);
    check("wrap_addr0", address, 32'hFFFFFFFF);
    @(negedge clk);
    check("wrap_addr1", address, 32'h00000000);
    start_burst(32'd500, 16'd5, 1'b0);
    wait_done(50);
    repeat (3) @(negedge clk);
    check("ignored_busy", 32'(busy), 0);
    check("ignored_valid", 32'(out_valid), 0);
    check("ignored_addr", address, 32'h00000000);
    check("wrap_queue_empty", q1.size(), 0);

    // Reset while the third of eight words is on the output.
    w0 = words1;
    start_burst(32'd60, 16'd8, 1'b1);
    cyc = 0;
    while (words1 - w0 < 2 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("reset_reached_word3", words1 - w0, 2);
    rst = 1'b1;
    q1.delete();
    dc = done_cnt;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_done", 32'(done), 0);
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_last", 32'(out_last), 0);
    check("mid_rst_addr", address, 0);
    check("mid_rst_data", out_data, 0);
    repeat (8) @(negedge clk);
    check("mid_rst_no_done", done_cnt - dc, 0);
    check("mid_rst_still_empty", 32'(out_valid), 0);
    w0 = words1;
    start_burst(32'd1, 16'd3, 1'b1);
    wait_done(50);
    check("post_rst_words", words1 - w0, 3);
    check("post_rst_queue", q1.size(), 0);

    // Latency-3 instance with random consumer stalls.
    @(posedge clk); #1;
    start3 = 1'b1; base3 = 32'd1000; count3 = 16'd64;
    for (int i = 0; i < 64; i++) begin
      logic [31:0] a;
      a = 32'd1000 + 32'(i);
      q3.push_back('{ram[a[7:0]], (i == 63)});
    end
    @(posedge clk); #1;
    start3 = 1'b0;
    cyc = 0;
    while (done3 !== 1'b1 && cyc < 3000) begin
      @(posedge clk); #1;
      ready3 = 1'($urandom_range(0, 1));
      @(negedge clk);
      cyc++;
    end
    check("l3_done", 32'(done3), 1);
    check("l3_words", words3, 64);
    check("l3_queue_empty", q3.size(), 0);

    check("we_zero", we_viol, 0);
    check("we3_zero", we_viol3, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ram_stream_reader.md
RAM_STREAM_READER -- requirements
Module: ram_stream_reader

Interface
REQ-001 SHALL have parameter READ_LATENCY, default 1: cycles from ram_address presented to ram_data_output valid; legal range 1..4.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: output buffer entries; power of two, at least READ_LATENCY+1.
REQ-003 SHALL have port clk, input, 1: single clock, all logic on the rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1: one-cycle request to begin a burst read.
REQ-006 SHALL have port base_addr, input, 32: first word address, sampled when start is accepted.
REQ-007 SHALL have port word_count, input, 16: number of words to read, sampled when start is accepted.
REQ-008 SHALL have port busy, output, 1: high from the accepted start until done.
REQ-009 SHALL have port done, output, 1: one-cycle pulse after the last word is handed off.
REQ-010 SHALL have port write_enable, output, 1: RAM write enable, tied 0.
REQ-011 SHALL have port address, output, 32: RAM word address.
REQ-012 SHALL have port data_input, output, 32: RAM write data, tied 0.
REQ-013 SHALL have port data_output, input, 32: RAM read data.
REQ-014 SHALL have port out_valid, output, 1: stream word available.
REQ-015 SHALL have port out_ready, input, 1: consumer accepts the word.
REQ-016 SHALL have port out_data, output, 32: stream word.
REQ-017 SHALL have port out_last, output, 1: high with the final word of the burst.

Function
REQ-018 SHALL use FSM states IDLE, ISSUE, DRAIN and FINISH.
REQ-019 SHALL accept start only in IDLE, latching base_addr and word_count; start in any other state is ignored.
REQ-020 SHALL go IDLE->ISSUE on accepted start with word_count>0, and IDLE->FINISH when word_count==0 (no reads, no stream words).
REQ-021 SHALL in ISSUE drive address=base_addr+issued_count each cycle a read is issued; address wraps modulo 2^32.
REQ-022 SHALL issue a read only when in-flight reads plus FIFO occupancy is below FIFO_DEPTH, so no returned word is ever dropped.
REQ-023 SHALL track in-flight reads with a READ_LATENCY-deep valid shift register and write data_output into the FIFO when the tail bit is set.
REQ-024 SHALL go ISSUE->DRAIN once word_count reads are issued, DRAIN->FINISH when in-flight is zero, the FIFO is empty and the last word is handshaked, and FINISH->IDLE after one cycle.
REQ-025 SHALL assert done for exactly the FINISH cycle; busy is high in ISSUE, DRAIN and FINISH.
REQ-026 SHALL present the FIFO head on out_data with out_valid=!empty; a word pops only on out_valid&&out_ready; out_data is held stable while out_valid&&!out_ready.
REQ-027 SHALL assert out_last on the word whose stream index equals word_count-1.
REQ-028 SHALL permit a FIFO push and pop in the same cycle when full or empty, with occupancy unchanged.
REQ-029 SHALL hold address at its last issued value when not issuing.
REQ-030 SHALL make first-word latency from accepted start to out_valid exactly READ_LATENCY+1 cycles when out_ready is held high, and sustain one word per cycle thereafter.

Reset
REQ-031 SHALL on rst force state IDLE, clear the counters, shift register and FIFO pointers, and drive busy=0, done=0, out_valid=0, out_last=0, address=0, out_data=0.
REQ-032 SHALL abort an in-progress burst on rst; data returning after reset is discarded and no done pulse is produced.

Structure
REQ-033 SHALL place the state enum and the 32-bit word and address width constants in a shared package ram_pkg.
REQ-034 SHALL implement the buffer as a sub-module ram_read_fifo (sync FIFO with full, empty and count outputs).

Verification
REQ-035 SHALL test the basic burst: RAM preloaded 1->FA32, 2->EA99, 3->1234, out_ready=1, start base=1 count=3 -> stream FA32, EA99, 1234 on consecutive cycles, out_last on 1234, done one cycle after.
REQ-036 SHALL test zero length: start count=0 -> no out_valid, busy for 1 cycle, done pulse, no address change.
REQ-037 SHALL test backpressure: count=8, out_ready low for 10 cycles -> at most FIFO_DEPTH words buffered, none lost or duplicated, in-order after release.
REQ-038 SHALL test wrap and ignored start: base=FFFFFFFF count=2 -> addresses FFFFFFFF then 00000000; a second start mid-burst -> ignored.
REQ-039 SHALL test reset mid-burst: rst during word 3 of 8 -> outputs at reset values next cycle, no done; a new burst then runs correctly.
REQ-040 SHALL test READ_LATENCY=3 with random out_ready over 64 words -> data matches the RAM model and write_enable stays 0 throughout.
